// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  // Controller state: normal issue, or holding for a multi-cycle Execute op.
  typedef enum logic [0:0] {
    StRun,
    StMulWait
  } state_e;

  // Execute operand source selects.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// Operand forwarding select for one Execute source register.
module forward_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output logic [1:0] fwd_sel
);

  // Memory is the younger producer, so it wins over Writeback; x0 never forwards.
  always_comb begin
    fwd_sel = FWD_RF;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      fwd_sel = FWD_MEM;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: stalls, flushes, forwarding, multi-cycle op
// wait with watchdog, and saturating stall/flush performance counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic [4:0]       rd_m,
  input  logic [4:0]       rd_w,
  input  logic             reg_write_e,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  input  logic             load_e,
  input  logic             pc_src_e,
  input  logic             mul_start_e,
  input  logic             mul_done_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_m,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic             mul_error,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned      WdW    = $clog2(MUL_TIMEOUT);
  localparam logic [WdW-1:0]   WdLast = WdW'(MUL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           state_q, state_d;
  logic [WdW-1:0]   wd_q, wd_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             branch_flush;
  logic             lu;

  forward_unit u_fwd_a (
    .rs          (rs1_e),
    .rd_m        (rd_m),
    .reg_write_m (reg_write_m),
    .rd_w        (rd_w),
    .reg_write_w (reg_write_w),
    .fwd_sel     (forward_a_e)
  );

  forward_unit u_fwd_b (
    .rs          (rs2_e),
    .rd_m        (rd_m),
    .reg_write_m (reg_write_m),
    .rd_w        (rd_w),
    .reg_write_w (reg_write_w),
    .fwd_sel     (forward_b_e)
  );

  // Load in Execute whose result a Decode source needs next cycle.
  assign lu = load_e && reg_write_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

  // Next-state and stall/flush decode; reset forces all controls low.
  always_comb begin
    state_d      = state_q;
    wd_d         = wd_q;
    err_d        = err_q;
    stall_f      = 1'b0;
    stall_d      = 1'b0;
    stall_e      = 1'b0;
    flush_d      = 1'b0;
    flush_e      = 1'b0;
    flush_m      = 1'b0;
    branch_flush = 1'b0;
    if (!reset) begin
      case (state_q)
        StRun: begin
          if (mul_start_e && !mul_done_e) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
            state_d = StMulWait;
            wd_d    = '0;
          end else if (pc_src_e) begin
            // Decode instruction is squashed, so a concurrent load-use is moot.
            flush_d      = 1'b1;
            flush_e      = 1'b1;
            branch_flush = 1'b1;
          end else if (lu) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end
        end
        StMulWait: begin
          if (mul_done_e) begin
            state_d = StRun;
          end else if (wd_q == WdLast) begin
            err_d   = 1'b1;
            state_d = StRun;
          end else begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
            wd_d    = wd_q + WdW'(1);
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  // State, watchdog and sticky error register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_f && (stall_cnt_q != CntMax)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (branch_flush && (flush_cnt_q != CntMax)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign mul_error   = err_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table plus multi-cycle sequences.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned Timeout = 8;
  localparam int unsigned CntW    = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic [4:0]      rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic            reg_write_e, reg_write_m, reg_write_w;
  logic            load_e, pc_src_e, mul_start_e, mul_done_e;
  logic            stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
  logic [1:0]      forward_a_e, forward_b_e;
  logic            mul_error;
  logic [CntW-1:0] stall_count, flush_count;

  int n_total = 0;
  int n_pass  = 0;

  pipeline_hazard_ctrl #(
    .MUL_TIMEOUT (Timeout),
    .CNT_W       (CntW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rs1_d       (rs1_d),
    .rs2_d       (rs2_d),
    .rs1_e       (rs1_e),
    .rs2_e       (rs2_e),
    .rd_e        (rd_e),
    .rd_m        (rd_m),
    .rd_w        (rd_w),
    .reg_write_e (reg_write_e),
    .reg_write_m (reg_write_m),
    .reg_write_w (reg_write_w),
    .load_e      (load_e),
    .pc_src_e    (pc_src_e),
    .mul_start_e (mul_start_e),
    .mul_done_e  (mul_done_e),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .stall_e     (stall_e),
    .flush_d     (flush_d),
    .flush_e     (flush_e),
    .flush_m     (flush_m),
    .forward_a_e (forward_a_e),
    .forward_b_e (forward_b_e),
    .mul_error   (mul_error),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );

  always #5 clock = ~clock;

  // ctl = {reg_write_e, reg_write_m, reg_write_w, load_e, pc_src_e, mul_start_e, mul_done_e}
  // exp = {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m}
  typedef struct {
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [6:0] ctl;
    logic [5:0] exp_ctl;
    logic [1:0] exp_fa, exp_fb;
  } vec_t;

  localparam int NVec = 14;
  vec_t vecs[NVec];

  function automatic vec_t mk(input logic [4:0] a_rs1_d, input logic [4:0] a_rs2_d,
                              input logic [4:0] a_rs1_e, input logic [4:0] a_rs2_e,
                              input logic [4:0] a_rd_e, input logic [4:0] a_rd_m,
                              input logic [4:0] a_rd_w, input logic [6:0] a_ctl,
                              input logic [5:0] a_exp, input logic [1:0] a_fa,
                              input logic [1:0] a_fb);
    vec_t v;
    v.rs1_d = a_rs1_d; v.rs2_d = a_rs2_d; v.rs1_e = a_rs1_e; v.rs2_e = a_rs2_e;
    v.rd_e = a_rd_e; v.rd_m = a_rd_m; v.rd_w = a_rd_w; v.ctl = a_ctl;
    v.exp_ctl = a_exp; v.exp_fa = a_fa; v.exp_fb = a_fb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [5:0] ctl_out();
    return {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m};
  endfunction

  task automatic clear_inputs();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    {reg_write_e, reg_write_m, reg_write_w, load_e, pc_src_e, mul_start_e, mul_done_e} = '0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic set_lu();
    load_e = 1'b1; reg_write_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
  endtask

  initial begin
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 7'b0000000, 6'b000000, 2'b00, 2'b00);
    vecs[1]  = mk(0, 0, 5, 3, 0, 5, 5, 7'b0110000, 6'b000000, 2'b10, 2'b00);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 7'b0110000, 6'b000000, 2'b00, 2'b00);
    vecs[3]  = mk(0, 0, 9, 9, 0, 4, 9, 7'b0110000, 6'b000000, 2'b01, 2'b01);
    vecs[4]  = mk(0, 0, 1, 9, 0, 9, 9, 7'b0010000, 6'b000000, 2'b00, 2'b01);
    vecs[5]  = mk(2, 7, 0, 0, 7, 0, 0, 7'b1001000, 6'b110010, 2'b00, 2'b00);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 7'b1001000, 6'b000000, 2'b00, 2'b00);
    vecs[7]  = mk(7, 0, 0, 0, 7, 0, 0, 7'b1000000, 6'b000000, 2'b00, 2'b00);
    vecs[8]  = mk(7, 0, 0, 0, 7, 0, 0, 7'b0001000, 6'b000000, 2'b00, 2'b00);
    vecs[9]  = mk(3, 0, 0, 0, 3, 0, 0, 7'b1001100, 6'b000110, 2'b00, 2'b00);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 7'b0000011, 6'b000000, 2'b00, 2'b00);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 7'b0000111, 6'b000110, 2'b00, 2'b00);
    vecs[12] = mk(0, 0, 31, 31, 0, 31, 31, 7'b0110000, 6'b000000, 2'b10, 2'b10);
    vecs[13] = mk(12, 0, 0, 0, 12, 0, 0, 7'b1001000, 6'b110010, 2'b00, 2'b00);

    // Reset state, with a load-use present to show controls are forced low.
    reset = 1'b1;
    clear_inputs();
    set_lu();
    #2;
    check("reset_ctl", 32'(ctl_out()), 32'd0);
    check("reset_stall_cnt", 32'(stall_count), 32'd0);
    check("reset_flush_cnt", 32'(flush_count), 32'd0);
    check("reset_mul_error", 32'(mul_error), 32'd0);
    do_reset();

    // Single-cycle vector table.
    for (int i = 0; i < NVec; i++) begin
      rs1_d = vecs[i].rs1_d; rs2_d = vecs[i].rs2_d;
      rs1_e = vecs[i].rs1_e; rs2_e = vecs[i].rs2_e;
      rd_e = vecs[i].rd_e; rd_m = vecs[i].rd_m; rd_w = vecs[i].rd_w;
      {reg_write_e, reg_write_m, reg_write_w, load_e, pc_src_e, mul_start_e, mul_done_e} =
        vecs[i].ctl;
      @(negedge clock);
      check($sformatf("vec%0d_ctl", i), 32'(ctl_out()), 32'(vecs[i].exp_ctl));
      check($sformatf("vec%0d_fwd_a", i), 32'(forward_a_e), 32'(vecs[i].exp_fa));
      check($sformatf("vec%0d_fwd_b", i), 32'(forward_b_e), 32'(vecs[i].exp_fb));
      next_cycle();
    end
    clear_inputs();
    @(negedge clock);
    check("table_stall_cnt", 32'(stall_count), 32'd2);
    check("table_flush_cnt", 32'(flush_count), 32'd2);

    // Multiply: done arrives 4 cycles after start -> 4 stall cycles.
    do_reset();
    mul_start_e = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check($sformatf("mul_stall%0d", i), 32'(ctl_out()), 32'b111001);
      next_cycle();
    end
    mul_done_e = 1'b1;
    @(negedge clock);
    check("mul_done_ctl", 32'(ctl_out()), 32'd0);
    next_cycle();
    clear_inputs();
    @(negedge clock);
    check("mul_back_run", 32'(ctl_out()), 32'd0);
    check("mul_no_error", 32'(mul_error), 32'd0);
    check("mul_stall_cnt", 32'(stall_count), 32'd4);

    // Watchdog: done never arrives -> 8 stall cycles, then abort with error.
    do_reset();
    mul_start_e = 1'b1;
    for (int i = 0; i < int'(Timeout); i++) begin
      @(negedge clock);
      check($sformatf("wd_stall%0d", i), 32'(ctl_out()), 32'b111001);
      next_cycle();
    end
    @(negedge clock);
    check("wd_abort_ctl", 32'(ctl_out()), 32'd0);
    check("wd_err_before_edge", 32'(mul_error), 32'd0);
    next_cycle();
    mul_start_e = 1'b0;
    @(negedge clock);
    check("wd_mul_error", 32'(mul_error), 32'd1);
    check("wd_back_run", 32'(ctl_out()), 32'd0);
    check("wd_stall_cnt", 32'(stall_count), 32'(Timeout));
    next_cycle();
    next_cycle();
    check("wd_error_sticky", 32'(mul_error), 32'd1);

    // Reset in the 2nd MULWAIT cycle.
    do_reset();
    mul_start_e = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clock);
    check("rst_pre_stall", 32'(ctl_out()), 32'b111001);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_ctl", 32'(ctl_out()), 32'd0);
    check("rst_mid_stall_cnt", 32'(stall_count), 32'd0);
    check("rst_mid_error", 32'(mul_error), 32'd0);
    next_cycle();
    reset = 1'b0;
    mul_start_e = 1'b0;
    @(negedge clock);
    check("rst_after_ctl", 32'(ctl_out()), 32'd0);
    next_cycle();
    check("rst_after_error", 32'(mul_error), 32'd0);
    check("rst_after_stall_cnt", 32'(stall_count), 32'd0);

    // Counter saturation at all-ones.
    do_reset();
    set_lu();
    repeat (20) next_cycle();
    check("sat_stall_cnt", 32'(stall_count), 32'hF);
    clear_inputs();
    pc_src_e = 1'b1;
    repeat (20) next_cycle();
    check("sat_flush_cnt", 32'(flush_count), 32'hF);
    check("sat_stall_hold", 32'(stall_count), 32'hF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage RISC-V pipeline. It drives the hold (`enable`) and `clear` inputs of the Fetch, Decode, Execute and Memory pipeline registers, and generates the Execute-stage operand forwarding selects. It also holds the pipeline while a multi-cycle multiply/divide operation occupies Execute, with a watchdog timeout, and keeps saturating stall/flush performance counters.

## Interface
- `MUL_TIMEOUT`, default 64: maximum cycles spent waiting in MULWAIT before a forced abort (≥2).
- `CNT_W`, default 32: width of the performance counters.
- `clock`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `rs1_d`, `rs2_d`  in  5: source registers of the instruction in Decode.
- `rs1_e`, `rs2_e`, `rd_e`  in  5: source and destination registers of the instruction in Execute.
- `rd_m`, `rd_w`  in  5: destination registers in Memory and Writeback.
- `reg_write_e`, `reg_write_m`, `reg_write_w`  in  1: register-write enables of the instructions in Execute, Memory and Writeback.
- `load_e`  in  1: the instruction in Execute is a load.
- `pc_src_e`  in  1: a branch or jump is taken in Execute.
- `mul_start_e`, `mul_done_e`  in  1: a multi-cycle operation is present in Execute; its result is ready.
- `stall_f`, `stall_d`, `stall_e`  out  1: hold the PC, Decode and Execute registers; connect to their `enable` inputs.
- `flush_d`, `flush_e`, `flush_m`  out  1: zero the Decode, Execute and Memory registers; connect to their `clear` inputs.
- `forward_a_e`, `forward_b_e`  out  2: operand source selects in Execute. 00 = register file, 01 = Writeback result, 10 = Memory ALU result.
- `mul_error`  out  1: sticky flag; set when the watchdog aborts a wait.
- `stall_count`, `flush_count`  out  CNT_W: performance counters.

## Operation
- FSM states: RUN and MULWAIT. Reset state is RUN.
- Forwarding, evaluated the same way for A (`rs1_e`) and B (`rs2_e`):
  - 10 if `reg_write_m` and `rd_m`≠0 and `rd_m`==rs.
  - Otherwise 01 if `reg_write_w` and `rd_w`≠0 and `rd_w`==rs.
  - Otherwise 00.
  - Memory wins when both match.
- Load-use hazard (`lu`): `load_e` & `reg_write_e` & `rd_e`≠0 & (`rd_e`==`rs1_d` | `rd_e`==`rs2_d`).
- Outputs in RUN, highest priority first:
  - `mul_start_e` & !`mul_done_e`: `stall_f`=`stall_d`=`stall_e`=1 and `flush_m`=1. Next state is MULWAIT and the watchdog is cleared.
  - `pc_src_e`: `flush_d`=`flush_e`=1, no stalls. A simultaneous `lu` is ignored because the Decode instruction is squashed.
  - `lu`: `stall_f`=`stall_d`=1 and `flush_e`=1.
  - Otherwise all stall/flush outputs are 0.
- `mul_start_e` and `mul_done_e` high together in RUN: no stall, stay in RUN.
- MULWAIT:
  - While `mul_done_e`=0 and watchdog < MUL_TIMEOUT-1: `stall_f`/`stall_d`/`stall_e`=1, `flush_m`=1, watchdog increments.
  - `mul_done_e`=1: all stall/flush outputs are 0 that cycle, next state is RUN.
  - Watchdog == MUL_TIMEOUT-1 with `mul_done_e`=0: outputs as on done, `mul_error` set to 1, next state is RUN.
  - `mul_start_e`, `pc_src_e` and `lu` are ignored.
- Counters:
  - `stall_count` increments on each cycle with `stall_f`=1.
  - `flush_count` increments on each cycle with `pc_src_e`-caused flushes.
  - Both saturate at all-ones and never wrap.
- Reset while asserted: state is RUN, watchdog, counters and `mul_error` are 0, and all stall/flush outputs are forced to 0. Forwarding outputs remain combinational.
- Reset mid-MULWAIT aborts the wait immediately and does not set `mul_error`.

## Timing
- Stall, flush and forward outputs are combinational from the inputs and the current state, with zero-cycle latency. They are valid before the clock edge at which the pipeline registers sample them.
- State, watchdog, counters and `mul_error` update on the rising clock edge. They clear asynchronously on reset.
- Load-use costs exactly 1 bubble cycle. A taken branch costs 2 squashed instructions.
- A multi-cycle op whose done arrives N cycles after start stalls for N cycles, the start cycle included.
- Only `reset` clears `mul_error`.

## Structure
- `pipe_ctrl_pkg` holds:
  - The state enum (RUN, MULWAIT).
  - Forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- Sub-module `forward_unit`: purely combinational, instantiated once per operand (A, B).
- The FSM, watchdog and counters live in the top level.

## Test plan
- Forwarding:
  - `rd_m`=`rd_w`=5, both writing, `rs1_e`=5 → `forward_a_e`=10.
  - `rd_m`=0, writing, `rs2_e`=0 → `forward_b_e`=00.
- Load-use: `load_e`=1, `rd_e`=7, `rs2_d`=7 → `stall_f`=`stall_d`=`flush_e`=1 for 1 cycle, then `stall_count`=1.
- Branch plus load-use in the same cycle: `pc_src_e`=1, `lu` true → `flush_d`=`flush_e`=1, `stall_f`=0, `flush_count`=1.
- Multiply: `mul_start_e`=1, `mul_done_e` rises 4 cycles later → stalls high for 4 cycles, deassert on the done cycle, state back to RUN, `mul_error`=0.
- Watchdog with MUL_TIMEOUT=8 and `mul_done_e` held at 0 → stalls for 8 cycles, then `mul_error`=1 and RUN.
- Reset asserted in the 2nd MULWAIT cycle → outputs drop to 0 at once, counters 0; after release `mul_start_e`=0 gives no stall.
